// File: rtl/command_dispatcher_if.sv
// command_dispatcher_if
//   Bundles the trace-command input bus and the cache-command output bus of
//   the command dispatcher.
//
//   Ports carried:
//     cmd_valid / cmd_ready / cmd_n[3:0] / cmd_addr[31:0]   trace command in
//     issue_valid / issue_ready / issue_n[3:0]
//     issue_tag / issue_index / issue_offset                cache command out
//     clear_req / print_req                                 one-cycle pulses
//
//   Handshake rule (both buses): a transfer happens on a rising clk edge where
//   valid and ready are both high. While valid is high and ready is low, the
//   producer holds valid and all payload fields unchanged. ready never
//   depends combinationally on valid.
//
//   Modports:
//     master - trace source and processor stage (drives cmd_*, issue_ready)
//     slave  - the dispatcher
interface command_dispatcher_if #(
    parameter int TAG_W    = 12,
    parameter int INDEX_W  = 14,
    parameter int OFFSET_W = 6
) ();
    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_n;
    logic [31:0]         cmd_addr;

    logic                issue_valid;
    logic                issue_ready;
    logic [3:0]          issue_n;
    logic [TAG_W-1:0]    issue_tag;
    logic [INDEX_W-1:0]  issue_index;
    logic [OFFSET_W-1:0] issue_offset;

    logic                clear_req;
    logic                print_req;

    modport master (
        output cmd_valid, cmd_n, cmd_addr, issue_ready,
        input  cmd_ready, issue_valid, issue_n, issue_tag, issue_index,
               issue_offset, clear_req, print_req
    );

    modport slave (
        input  cmd_valid, cmd_n, cmd_addr, issue_ready,
        output cmd_ready, issue_valid, issue_n, issue_tag, issue_index,
               issue_offset, clear_req, print_req
    );
endinterface

// File: rtl/command_dispatcher.sv
// command_dispatcher
//   Accepts trace commands, queues legal ones in a small in-order FIFO and
//   dispatches them one at a time: cache opcodes (0-4) are presented on the
//   issue bus until consumed, opcode 8 becomes a clear_req pulse and opcode 9
//   a print_req pulse. Illegal opcodes are accepted and discarded.
//
//   Ports:
//     clk         rising-edge clock
//     rst         asynchronous active-high reset
//     bus         command_dispatcher_if.slave (cmd_*, issue_*, clear/print)
//     count       FIFO occupancy, 0..DEPTH
//     issued_cnt  cache commands consumed on the issue bus, wraps at 2^16
//     drop_cnt    illegal opcodes discarded, saturates at 255
//     state_dbg   current FSM state (IDLE=0, ISSUE=1, CLEAR=2, PRINT=3)
module command_dispatcher #(
    parameter int DEPTH    = 4,
    parameter int TAG_W    = 12,
    parameter int INDEX_W  = 14,
    parameter int OFFSET_W = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    command_dispatcher_if.slave        bus,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                issued_cnt,
    output logic [7:0]                 drop_cnt,
    output logic [1:0]                 state_dbg
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CLEAR = 2'd2,
        S_PRINT = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [3:0]       mem_n    [DEPTH];
    logic [31:0]      mem_addr [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             accept;
    logic             legal;
    logic             push;
    logic             pop;
    logic             load_issue;
    logic             fifo_empty;
    logic [3:0]       head_n;
    logic [31:0]      head_addr;

    // ------------------------------------------------------------------
    // Input side. cmd_ready looks only at the registered count (and rst),
    // so nothing on the issue side can reach it combinationally.
    // ------------------------------------------------------------------
    assign bus.cmd_ready = (count < CNT_W'(DEPTH)) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        legal = 1'b0;
        case (bus.cmd_n)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
    end

    assign push       = accept && legal;
    assign fifo_empty = (count == '0);
    assign head_n     = mem_n[rd_ptr];
    assign head_addr  = mem_addr[rd_ptr];

    // ------------------------------------------------------------------
    // FIFO storage. The array carries no reset: an entry is only ever read
    // after it has been written, and count/pointers are reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_n[wr_ptr]    <= bus.cmd_n;
            mem_addr[wr_ptr] <= bus.cmd_addr;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM. The head entry stays in the FIFO (and in count) until
    // the cycle it is popped, so a command waiting on issue_ready still
    // occupies a slot.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        pop        = 1'b0;
        load_issue = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    case (head_n)
                        4'd8:    state_d = S_CLEAR;
                        4'd9:    state_d = S_PRINT;
                        default: begin
                            state_d    = S_ISSUE;
                            load_issue = 1'b1;
                        end
                    endcase
                end
            end
            S_ISSUE: begin
                if (bus.issue_ready) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CLEAR: begin
                pop     = 1'b1;
                state_d = S_IDLE;
            end
            S_PRINT: begin
                pop     = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes are pure decodes of the state register, so they are mutually
    // exclusive by construction and drop in the same cycle rst rises.
    assign bus.issue_valid = (state_q == S_ISSUE);
    assign bus.clear_req   = (state_q == S_CLEAR);
    assign bus.print_req   = (state_q == S_PRINT);
    assign state_dbg       = state_q;

    // ------------------------------------------------------------------
    // Issue payload registers: loaded once on IDLE->ISSUE and then frozen
    // until the next load, which keeps them stable through any stall.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.issue_n      <= '0;
            bus.issue_tag    <= '0;
            bus.issue_index  <= '0;
            bus.issue_offset <= '0;
        end else if (load_issue) begin
            bus.issue_n      <= head_n;
            bus.issue_tag    <= head_addr[31 -: TAG_W];
            bus.issue_index  <= head_addr[OFFSET_W +: INDEX_W];
            bus.issue_offset <= head_addr[OFFSET_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Statistics.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued_cnt <= '0;
            drop_cnt   <= '0;
        end else begin
            if ((state_q == S_ISSUE) && bus.issue_ready)
                issued_cnt <= issued_cnt + 16'd1;
            if (accept && !legal && (drop_cnt != 8'hFF))
                drop_cnt <= drop_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_command_dispatcher.sv
// tb_command_dispatcher
//   Scoreboard bench for command_dispatcher. Every accepted legal command
//   pushes its expected dispatch event onto exp_q; every issue handshake,
//   clear_req or print_req pulse pops and compares the head. Small models
//   track occupancy, issued and dropped counts from observed handshakes.
module tb_command_dispatcher;
    localparam int DEPTH = 4;
    localparam int EV_W  = 38;   // {kind[1:0], n[3:0], addr/fields[31:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  count;
    logic [15:0] issued_cnt;
    logic [7:0]  drop_cnt;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    command_dispatcher_if #(.TAG_W(12), .INDEX_W(14), .OFFSET_W(6)) bus ();

    command_dispatcher #(
        .DEPTH(DEPTH), .TAG_W(12), .INDEX_W(14), .OFFSET_W(6)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .count      (count),
        .issued_cnt (issued_cnt),
        .drop_cnt   (drop_cnt),
        .state_dbg  (state_dbg)
    );

    int checks   = 0;
    int failures = 0;

    logic [EV_W-1:0] exp_q[$];
    int              m_count  = 0;
    int              m_issued = 0;
    int              m_drop   = 0;
    int              clear_seen = 0;
    int              print_seen = 0;
    logic            prev_stall = 1'b0;
    logic [35:0]     prev_fields = '0;
    bit              rand_done = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_legal(input logic [3:0] n);
        return (n <= 4'd4) || (n == 4'd8) || (n == 4'd9);
    endfunction

    // Expected event: kind 1 = issue (address split kept as tag|index|offset,
    // which is simply the 32-bit address), 2 = clear, 3 = print.
    function automatic logic [EV_W-1:0] exp_event(input logic [3:0] n, input logic [31:0] a);
        logic [1:0] kind;
        kind = (n == 4'd8) ? 2'd2 : (n == 4'd9) ? 2'd3 : 2'd1;
        return {kind, n, (kind == 2'd1) ? a : 32'h0};
    endfunction

    task automatic sb_pop(input string tag, input logic [EV_W-1:0] obs);
        logic [EV_W-1:0] e;
        check_eq({tag, "_sb_nonempty"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(tag, obs, e);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor / scoreboard, sampling on the falling edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        logic [35:0] cur_fields;
        int          pushes;
        int          pops;
        cur_fields = {bus.issue_n, bus.issue_tag, bus.issue_index, bus.issue_offset};
        if (rst) begin
            exp_q.delete();
            m_count    = 0;
            m_issued   = 0;
            m_drop     = 0;
            prev_stall = 1'b0;
        end else begin
            pushes = 0;
            pops   = 0;
            check_eq("count", count, m_count);
            check_eq("issued_cnt", issued_cnt, m_issued);
            check_eq("drop_cnt", drop_cnt, m_drop);
            check_eq("cmd_ready", bus.cmd_ready, m_count < DEPTH);
            check_eq("strobe_excl",
                     32'(bus.issue_valid) + 32'(bus.clear_req) + 32'(bus.print_req) <= 1, 1);
            if (prev_stall && bus.issue_valid)
                check_eq("issue_hold", cur_fields, prev_fields);

            if (bus.issue_valid && bus.issue_ready) begin
                sb_pop("issue_ev", {2'd1, cur_fields});
                m_issued = (m_issued + 1) % 65536;
                pops = 1;
            end
            if (bus.clear_req) begin
                sb_pop("clear_ev", {2'd2, 4'd8, 32'h0});
                clear_seen++;
                pops = 1;
            end
            if (bus.print_req) begin
                sb_pop("print_ev", {2'd3, 4'd9, 32'h0});
                print_seen++;
                pops = 1;
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                if (is_legal(bus.cmd_n)) begin
                    exp_q.push_back(exp_event(bus.cmd_n, bus.cmd_addr));
                    pushes = 1;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
            m_count    = m_count + pushes - pops;
            prev_stall = bus.issue_valid && !bus.issue_ready;
            prev_fields = cur_fields;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks. Inputs change 1 time unit after the rising edge.
    // ------------------------------------------------------------------
    task automatic push_cmd(input logic [3:0] n, input logic [31:0] a);
        bit done;
        done = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_n     = n;
        bus.cmd_addr  = a;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            done = bus.cmd_ready;
            @(posedge clk);
            #1;
        end
        check_eq("push_accept", done, 1);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = (exp_q.size() == 0) && (state_dbg == 2'd0) && (count == 3'd0);
        end
        check_eq("drain_done", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus.
    // ------------------------------------------------------------------
    initial begin
        logic [3:0] op_tab [9];
        int         c0;
        int         p0;
        bit         seen;
        op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd5, 4'd12};

        bus.cmd_valid   = 1'b0;
        bus.cmd_n       = 4'd0;
        bus.cmd_addr    = 32'h0;
        bus.issue_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", bus.cmd_ready, 0);
        check_eq("rst_issue_valid", bus.issue_valid, 0);
        check_eq("rst_count", count, 0);
        check_eq("rst_state", state_dbg, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_eq("post_rst_cmd_ready", bus.cmd_ready, 1);

        // Single read: latency, address split, issued_cnt
        bus.issue_ready = 1'b1;
        push_cmd(4'd0, 32'h1234_5678);
        @(negedge clk);
        check_eq("lat_cycle1_valid", bus.issue_valid, 0);
        @(negedge clk);
        check_eq("lat_cycle2_valid", bus.issue_valid, 1);
        check_eq("split_tag", bus.issue_tag, 12'h123);
        check_eq("split_index", bus.issue_index, 14'h1159);
        check_eq("split_offset", bus.issue_offset, 6'h38);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("issued_after_one", issued_cnt, 1);
        drain();

        // Fill to full with a stalled consumer, fifth held back, 10-cycle stall
        bus.issue_ready = 1'b0;
        push_cmd(4'd0, 32'hAAAA_0001);
        push_cmd(4'd1, 32'hBBBB_0042);
        push_cmd(4'd2, 32'hCCCC_00FF);
        push_cmd(4'd3, 32'hDDDD_1234);
        fork
            push_cmd(4'd4, 32'hEEEE_5555);
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    check_eq("full_cmd_ready", bus.cmd_ready, 0);
                    check_eq("full_count", count, 4);
                    check_eq("full_issue_n", bus.issue_n, 0);
                end
                @(posedge clk);
                #1;
                bus.issue_ready = 1'b1;
            end
        join
        drain();

        // Mixed ordering: ifetch, clear, write, print
        c0 = clear_seen;
        p0 = print_seen;
        push_cmd(4'd2, 32'h0000_1000);
        push_cmd(4'd8, 32'h0);
        push_cmd(4'd1, 32'hFFFF_FFC0);
        push_cmd(4'd9, 32'h0);
        drain();
        check_eq("clear_pulses", clear_seen - c0, 1);
        check_eq("print_pulses", print_seen - p0, 1);

        // Illegal opcodes and drop saturation
        push_cmd(4'd5, 32'h1111_1111);
        push_cmd(4'd15, 32'h2222_2222);
        @(negedge clk);
        check_eq("illegal_count", count, 0);
        check_eq("illegal_drop2", drop_cnt, 2);
        check_eq("illegal_no_issue", bus.issue_valid, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 300; i++)
            push_cmd(4'($urandom_range(10, 15)), $urandom);
        @(negedge clk);
        check_eq("drop_saturate", drop_cnt, 255);
        @(posedge clk);
        #1;

        // Reset in the middle of an ISSUE with three entries queued
        bus.issue_ready = 1'b0;
        push_cmd(4'd0, 32'h0101_0101);
        push_cmd(4'd1, 32'h0202_0202);
        push_cmd(4'd2, 32'h0303_0303);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.issue_valid && (count == 3'd3);
        end
        check_eq("pre_rst_issue_full3", seen, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_issue_valid", bus.issue_valid, 0);
        check_eq("midrst_count", count, 0);
        check_eq("midrst_cmd_ready", bus.cmd_ready, 0);
        check_eq("midrst_issued", issued_cnt, 0);
        check_eq("midrst_drop", drop_cnt, 0);
        check_eq("midrst_tag", bus.issue_tag, 0);
        wait_cycles(2);
        rst = 1'b0;
        #1;
        check_eq("rerst_cmd_ready", bus.cmd_ready, 1);
        bus.issue_ready = 1'b1;
        push_cmd(4'd3, 32'h0BAD_F00D);
        drain();
        check_eq("rerst_issued", issued_cnt, 1);

        // Random traffic with a randomly stalling consumer
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    push_cmd(op_tab[$urandom_range(0, 8)], $urandom);
                    if ($urandom_range(0, 3) == 0)
                        wait_cycles($urandom_range(1, 3));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.issue_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        bus.issue_ready = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/command_dispatcher.md
COMMAND_DISPATCHER -- requirements
Module: command_dispatcher

Interface
REQ-001 DEPTH, 4, command FIFO entries; power of two, 2..16.
REQ-002 TAG_W, 12, tag field width; INDEX_W, 14, set index width; OFFSET_W, 6, byte offset width; TAG_W+INDEX_W+OFFSET_W = 32.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 cmd_valid  in  1  trace command present.
REQ-006 cmd_ready  out  1  dispatcher accepts command this cycle.
REQ-007 cmd_n  in  4  trace opcode: 0 read, 1 write, 2 ifetch, 3 invalidate, 4 snoop, 8 clear, 9 print.
REQ-008 cmd_addr  in  32  trace byte address.
REQ-009 issue_valid  out  1  cache command presented to the processor stage.
REQ-010 issue_ready  in  1  processor stage consumes the command.
REQ-011 issue_n  out  4  opcode of issued command.
REQ-012 issue_tag / issue_index / issue_offset  out  TAG_W / INDEX_W / OFFSET_W  address split, tag = addr[31 -: TAG_W], offset = addr[OFFSET_W-1:0], index between.
REQ-013 clear_req  out  1  one-cycle pulse for opcode 8.
REQ-014 print_req  out  1  one-cycle pulse for opcode 9.
REQ-015 count  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
REQ-016 issued_cnt  out  16  commands handed over on issue handshake (opcodes 0-4), wraps modulo 2^16.
REQ-017 drop_cnt  out  8  illegal opcodes discarded, saturates at 255.

Function
REQ-018 Input handshake completes when cmd_valid && cmd_ready; cmd_ready = (count < DEPTH) && !rst, from registered count only.
REQ-019 Accepted opcodes in {0,1,2,3,4,8,9} SHALL be written to FIFO tail; other opcodes complete handshake, are not stored, drop_cnt increments.
REQ-020 FIFO read/write pointers wrap modulo DEPTH; strict arrival order preserved across all opcode types, including 8/9.
REQ-021 Same-cycle push and pop SHALL leave count unchanged; push at full never occurs since cmd_ready = 0.
REQ-022 FSM states: IDLE, ISSUE, CLEAR, PRINT.
REQ-023 IDLE: FIFO empty -> stay; head opcode 8 -> CLEAR; 9 -> PRINT; 0-4 -> ISSUE, loading head into issue registers.
REQ-024 ISSUE: issue_valid = 1, issue_n/tag/index/offset held stable until issue_ready sampled high; then pop head, issued_cnt++, next state IDLE.
REQ-025 CLEAR: clear_req = 1 for exactly this cycle, pop head, next IDLE; PRINT identical with print_req.
REQ-026 Peak throughput one dispatched command per two cycles; latency from accepted command into empty FIFO to issue_valid = 2 cycles.
REQ-027 issue_valid, clear_req, print_req mutually exclusive in every cycle.
REQ-028 issue_ready while not in ISSUE SHALL be ignored.
REQ-029 Outputs are registered; no combinational path cmd_* -> issue_* or issue_ready -> cmd_ready.

Reset
REQ-030 rst asserted at any time, including mid-ISSUE, SHALL immediately force state IDLE, FIFO empty, pointers 0, count 0, issue_valid/clear_req/print_req 0, issue fields 0, issued_cnt 0, drop_cnt 0, cmd_ready 0.
REQ-031 Pending unconsumed commands at reset are discarded; first rising edge after rst deassertion sees cmd_ready = 1.

Verification
REQ-032 Push {n=0, addr=0x1234_5678} with issue_ready=1 -> two cycles later issue_valid=1, tag=0x123, index=0x1159, offset=0x38; issued_cnt=1.
REQ-033 Push 5 commands back-to-back, issue_ready=0 -> count reaches 4, cmd_ready=0 on 5th, 5th held by source and accepted only after first pop.
REQ-034 Push sequence 2, 8, 1, 9 -> observe ifetch issue, clear_req pulse, write issue, print_req pulse, in that order, one pulse cycle each.
REQ-035 Push n=5 and n=15 -> no issue activity, count stays 0, drop_cnt=2; 300 illegal pushes -> drop_cnt=255.
REQ-036 Assert rst while issue_valid=1 with count=3 -> same cycle issue_valid=0, count=0; after release, new command issues normally with issued_cnt restarting at 1.
REQ-037 Hold issue_ready=0 for 10 cycles in ISSUE -> issue_* fields unchanged every cycle; single pop on release.
